tick_led_sequencer: RTL and testbench

TICK_LED_SEQUENCER -- requirements
Module: tick_led_sequencer

---
 rtl/tick_led_sequencer.sv | 143 ++++++++++++++
 tb/tb_tick_led_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tick_led_sequencer
// Function : Synchronises a slow tick, steps a BLINK/SHIFT/BOUNCE/FILL LED
//            pattern on each tick rising edge. Optional PWM dimming: LED_DIM_EN
// Revision : 1.0 - initial release
// ============================================================================
module tick_led_sequencer #(
    parameter int LED_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             TICK_IN,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [3:0]       DUTY,
    output logic [LED_W-1:0] LED,
    output logic             STEP
);
    localparam int               c_CNT_W      = $clog2(LED_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(LED_W);
    localparam logic [2:0]       c_GUARD_MAX  = 3'(SYNC_STAGES + 1);
    localparam logic [LED_W-1:0] c_ONE        = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       c_MODE_BLINK  = 2'b00;
    localparam logic [1:0]       c_MODE_SHIFT  = 2'b01;
    localparam logic [1:0]       c_MODE_BOUNCE = 2'b10;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [2:0]             r_guard;
    logic                   r_step;
    logic                   w_edge;
    logic [1:0]             r_mode;
    logic [1:0]             r_mode_prev;
    logic                   w_load;
    logic                   w_adv;
    logic [LED_W-1:0]       r_pat;
    logic [LED_W-1:0]       w_pat_nxt;
    logic                   r_dir_up;
    logic                   w_dir_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [LED_W-1:0]       r_led;
    logic [LED_W-1:0]       w_led_nxt;

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_load = (r_mode != r_mode_prev);
    assign w_adv  = r_step & EN;
    assign STEP   = r_step;
    assign LED    = r_led;

    // The guard counter blocks a tick that was already high at reset release
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync  <= '0;
            r_hist  <= 1'b0;
            r_guard <= '0;
            r_step  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], TICK_IN};
            r_hist  <= r_sync[SYNC_STAGES-1];
            r_step  <= w_edge & (r_guard == c_GUARD_MAX);
            if (r_guard != c_GUARD_MAX) begin
                r_guard <= r_guard + 3'd1;
            end
        end
    end

    always_comb begin
        w_pat_nxt = r_pat;
        w_dir_nxt = r_dir_up;
        w_cnt_nxt = r_cnt;
        if (w_load) begin
            w_dir_nxt = 1'b1;
            w_cnt_nxt = '0;
            w_pat_nxt = ((r_mode == c_MODE_SHIFT) || (r_mode == c_MODE_BOUNCE)) ? c_ONE : '0;
        end else if (w_adv) begin
            case (r_mode)
                c_MODE_BLINK: w_pat_nxt = ~r_pat;
                c_MODE_SHIFT: w_pat_nxt = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
                c_MODE_BOUNCE: begin
                    // Direction flips as the end bit is reached, so no dwell at the ends
                    if (r_dir_up) begin
                        w_pat_nxt = r_pat << 1;
                        if (r_pat[LED_W-2]) w_dir_nxt = 1'b0;
                    end else begin
                        w_pat_nxt = r_pat >> 1;
                        if (r_pat[1]) w_dir_nxt = 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == c_CNT_MAX) begin
                        w_pat_nxt = '0;
                        w_cnt_nxt = '0;
                    end else begin
                        w_pat_nxt = {r_pat[LED_W-2:0], 1'b1};
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mode      <= c_MODE_BLINK;
            r_mode_prev <= c_MODE_BLINK;
            r_pat       <= '0;
            r_dir_up    <= 1'b1;
            r_cnt       <= '0;
            r_led       <= '0;
        end else begin
            r_mode      <= MODE;
            r_mode_prev <= r_mode;
            r_pat       <= w_pat_nxt;
            r_dir_up    <= w_dir_nxt;
            r_cnt       <= w_cnt_nxt;
            r_led       <= w_led_nxt;
        end
    end

`ifdef LED_DIM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
        end
    end

    assign w_led_nxt = EN ? (r_pat & {LED_W{(r_pwm < DUTY)}}) : '0;
`else
    logic w_unused_duty;

    assign w_unused_duty = ^DUTY;
    assign w_led_nxt     = EN ? r_pat : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_led_sequencer
// Function : Directed bench for tick_led_sequencer with a step-count model
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_led_sequencer;
    localparam int W = 8;
    localparam int S = 2;

    logic         CLK     = 1'b0;
    logic         RST_N   = 1'b1;
    logic         TICK_IN = 1'b0;
    logic         EN      = 1'b1;
    logic [1:0]   MODE    = 2'b00;
    logic [3:0]   DUTY    = 4'd15;
    logic [W-1:0] LED;
    logic         STEP;

    int checks    = 0;
    int failures  = 0;
    int step_seen = 0;

    tick_led_sequencer #(.LED_W(W), .SYNC_STAGES(S)) dut (
        .CLK(CLK), .RST_N(RST_N), .TICK_IN(TICK_IN), .EN(EN),
        .MODE(MODE), .DUTY(DUTY), .LED(LED), .STEP(STEP)
    );

    always #5 CLK = ~CLK;

    // Pattern as a function of the number of steps taken since the last load
    function automatic logic [W-1:0] pat_of(input int md, input int k);
        longint one;
        int     p;
        one = 1;
        case (md)
            0:       return (k % 2 == 1) ? {W{1'b1}} : {W{1'b0}};
            1:       return W'(one << (k % W));
            2: begin
                p = k % (2 * W - 2);
                if (p >= W) p = 2 * W - 2 - p;
                return W'(one << p);
            end
            default: return W'((one << (k % (W + 1))) - 1);
        endcase
    endfunction

    logic [1:0]   mm1 = 2'b00;
    logic [1:0]   mm2 = 2'b00;
    int           pmode = 0;
    int           kk = 0;
    int           n_edges = 0;
    logic         m_step = 1'b0;
    logic [W-1:0] m_led = '0;
    logic [W-1:0] m_tmp;
    logic         sh [0:S+1];

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mm1 = 2'b00; mm2 = 2'b00; pmode = 0; kk = 0; n_edges = 0;
            m_step = 1'b0; m_led = '0;
            for (int i = 0; i <= S + 1; i++) sh[i] = 1'b0;
        end else begin
            m_tmp = pat_of(pmode, kk);
`ifdef LED_DIM_EN
            if ((n_edges % 16) >= int'(DUTY)) m_tmp = '0;
`endif
            m_led = EN ? m_tmp : '0;
            if (mm1 != mm2) begin
                pmode = int'(mm1);
                kk    = 0;
            end else if (m_step && EN) begin
                kk++;
            end
            mm2 = mm1;
            mm1 = MODE;
            n_edges++;
            for (int i = S + 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0]  = TICK_IN;
            m_step = (n_edges > S + 1) && sh[S] && !sh[S+1];
        end
    end

    always @(negedge CLK) begin
        checks++;
        if (LED !== m_led) begin
            failures++;
            $display("FAIL model_led t=%0t: got %02h expected %02h", $time, LED, m_led);
        end
        checks++;
        if (STEP !== m_step) begin
            failures++;
            $display("FAIL model_step t=%0t: got %0b expected %0b", $time, STEP, m_step);
        end
        if (STEP === 1'b1) step_seen++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK) TICK_IN = 1'b1;
        repeat (6) @(negedge CLK);
        TICK_IN = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    logic [7:0] bounce_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_exp [10]   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                    8'hFF, 8'h00, 8'h01};
    int s0;
    int on_cnt;

    initial begin
        #2 RST_N = 1'b0;
        TICK_IN = 1'b1;
        MODE    = 2'b01;
        repeat (3) @(negedge CLK);
        chk("reset_led", LED, 0);
        chk("reset_step", STEP, 0);
        s0 = step_seen;
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        chk("no_step_at_release", step_seen, s0);
        chk("shift_load", LED, 8'h01);
        TICK_IN = 1'b0;
        repeat (4) @(negedge CLK);

        s0 = step_seen;
        @(negedge CLK) TICK_IN = 1'b1;
        @(posedge CLK) #1 chk("lat_e0", STEP, 0);
        @(posedge CLK) #1 chk("lat_e1", STEP, 0);
        @(posedge CLK) #1 chk("lat_e2", STEP, 1);
        @(posedge CLK) #1 chk("lat_e3", STEP, 0);
        repeat (3) @(negedge CLK);
        TICK_IN = 1'b0;
        repeat (6) @(negedge CLK);
        chk("shift_1", LED, 8'h02);
        tick(); chk("shift_2", LED, 8'h04);
        tick(); chk("shift_3", LED, 8'h08);
        chk("step_count_3", step_seen - s0, 3);
        repeat (4) tick();
        chk("shift_msb", LED, 8'h80);
        tick(); chk("shift_wrap", LED, 8'h01);
        repeat (3) tick();
        chk("shift_back", LED, 8'h08);

        @(negedge CLK) MODE = 2'b10;
        repeat (4) @(negedge CLK);
        chk("bounce_load", LED, 8'h01);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("bounce_seq", LED, {24'd0, bounce_exp[i]});
        end

        @(negedge CLK) MODE = 2'b11;
        repeat (4) @(negedge CLK);
        chk("fill_load", LED, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fill_seq", LED, {24'd0, fill_exp[i]});
        end

        @(negedge CLK) MODE = 2'b01;
        repeat (4) @(negedge CLK);
        tick(); chk("pre_coincide", LED, 8'h02);
        @(negedge CLK) TICK_IN = 1'b1;
        @(negedge CLK);
        @(negedge CLK) MODE = 2'b00;
        repeat (4) @(negedge CLK);
        TICK_IN = 1'b0;
        repeat (6) @(negedge CLK);
        chk("load_beats_step", LED, 8'h00);
        tick(); chk("blink_after_load", LED, 8'hFF);

        @(negedge CLK) MODE = 2'b01;
        repeat (4) @(negedge CLK);
        tick(); chk("en_pre", LED, 8'h02);
        @(negedge CLK) EN = 1'b0;
        repeat (2) @(negedge CLK);
        chk("en_off_led", LED, 0);
        tick(); tick();
        chk("en_off_hold", LED, 0);
        EN = 1'b1;
        repeat (2) @(negedge CLK);
        chk("en_resume", LED, 8'h02);
        tick(); chk("en_next", LED, 8'h04);

        @(negedge CLK) #3 RST_N = 1'b0;
        #1 chk("async_abort", LED, 0);
        @(negedge CLK) RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        chk("reset_mode_reload", LED, 8'h01);

        @(negedge CLK) MODE = 2'b00;
        repeat (4) @(negedge CLK);
        chk("blink_load", LED, 8'h00);
        tick();
`ifdef LED_DIM_EN
        DUTY = 4'd4;
        @(negedge CLK);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (LED == 8'hFF) on_cnt++;
        end
        chk("duty4_on_cycles", on_cnt, 4);
        DUTY = 4'd0;
        @(negedge CLK);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (LED != 8'h00) on_cnt++;
        end
        chk("duty0_on_cycles", on_cnt, 0);
`else
        DUTY = 4'd0;
        @(negedge CLK);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (LED == 8'hFF) on_cnt++;
        end
        chk("duty_ignored", on_cnt, 16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
